// File: rtl/mdu_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// MDU_ACC_EN adds the ACC state used by MADD/MADDU/MSUB/MSUBU.
package mdu_ctrl_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_t;

`ifdef MDU_ACC_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4,
    ST_ACC  = 3'd5
  } mdu_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;
`endif

  // Even op codes are the signed variants.
  function automatic logic is_signed(input mdu_op_t op);
    return !op[0];
  endfunction

  function automatic logic is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic is_sub(input mdu_op_t op);
    return op[2] && op[1];
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage to multiply/divide controller bus.
// Operand, op and HI/LO result signals; MDU_ACC_EN makes hi_i/lo_i live.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  // start_i is taken only while the unit is IDLE and cancel_i is low; stall_o
  // is high from that acceptance cycle until the result cycle, result_valid_o
  // pulses once with hi_o/lo_o, and start_i seen while busy_o is high is ignored.
  logic        start_i;
  mdu_op_t     op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        cancel_i;
  logic        stall_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, hi_i, lo_i, cancel_i,
    input  stall_o, busy_o, result_valid_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, hi_i, lo_i, cancel_i,
    output stall_o, busy_o, result_valid_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider datapath: magnitude load, shift/subtract, sign fix.
// Sequenced by mdu_ctrl through i_start / i_iter / i_fix.
module mdu_div_core
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_iter,
  input  logic        i_fix,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;

  assign w_a_neg = i_signed && i_a[31];
  assign w_b_neg = i_signed && i_b[31];

  // Dividend shifts out of r_quo's top while quotient bits enter at the bottom.
  // A zero divisor never borrows, giving all-ones quotient and remainder = |a|.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[31:0] - r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_rem   <= '0;
      r_quo   <= w_a_neg ? -i_a : i_a;
      r_div   <= w_b_neg ? -i_b : i_b;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (i_iter) begin
      if (w_ge) begin
        r_rem <= w_diff;
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

  assign o_quo = (i_fix && r_neg_q) ? -r_quo : r_quo;
  assign o_rem = (i_fix && r_neg_r) ? -r_rem : r_rem;

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller: one-cycle multiply, 32-step divide.
// Define MDU_ACC_EN to add MADD/MADDU/MSUB/MSUBU via an ACC state.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  bus,
  output mdu_state_t o_dbg_state
);

  mdu_state_t       r_state;
  mdu_state_t       w_next;
  mdu_op_t          r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic        w_op_ok;
  logic        w_accept;
  logic        w_stall;
  logic        w_busy;
  logic        w_valid;
  logic        w_div_start;
  logic        w_div_iter;
  logic        w_div_fix;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

`ifdef MDU_ACC_EN
  logic [63:0] r_prod;
  assign w_op_ok = 1'b1;
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{bus.hi_i, bus.lo_i};
  // Accumulate codes are not accepted at all, so they behave as no-ops.
  assign w_op_ok = !is_acc(bus.op_i);
`endif

  assign w_accept = (r_state == ST_IDLE) && bus.start_i && !bus.cancel_i && w_op_ok;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.cancel_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_next = is_div(bus.op_i) ? ST_DIV : ST_MUL;
`ifdef MDU_ACC_EN
        ST_MUL:  w_next = is_acc(r_op) ? ST_ACC : ST_DONE;
        ST_ACC:  w_next = ST_DONE;
`else
        ST_MUL:  w_next = ST_DONE;
`endif
        ST_DIV:  if (r_cnt == CNT_W'(DIV_ITER - 1)) w_next = ST_FIX;
        ST_FIX:  w_next = ST_DONE;
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall     = 1'b0;
    w_valid     = 1'b0;
    w_div_start = 1'b0;
    w_div_iter  = 1'b0;
    w_div_fix   = 1'b0;
    w_busy      = (r_state != ST_IDLE) && !rst;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          w_stall     = w_accept;
          w_div_start = w_accept && is_div(bus.op_i);
        end
        ST_MUL:  w_stall = 1'b1;
`ifdef MDU_ACC_EN
        ST_ACC:  w_stall = 1'b1;
`endif
        ST_DIV: begin
          w_stall    = 1'b1;
          w_div_iter = 1'b1;
        end
        ST_FIX: begin
          w_stall   = 1'b1;
          w_div_fix = 1'b1;
        end
        // Stall drops in DONE so EX advances on the HI/LO write edge.
        ST_DONE: w_valid = !bus.cancel_i;
        default: ;
      endcase
    end
  end

  assign w_ext_a = is_signed(r_op) ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
  assign w_ext_b = is_signed(r_op) ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= OP_MULT;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
`ifdef MDU_ACC_EN
      r_prod <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_op <= bus.op_i;
        r_a  <= bus.src_a_i;
        r_b  <= bus.src_b_i;
      end
      r_cnt <= w_div_iter ? r_cnt + CNT_W'(1) : '0;
      if (!bus.cancel_i) begin
        case (r_state)
`ifdef MDU_ACC_EN
          ST_MUL: begin
            if (is_acc(r_op)) r_prod <= w_prod;
            else              {r_hi, r_lo} <= w_prod;
          end
          ST_ACC: {r_hi, r_lo} <= is_sub(r_op) ? {bus.hi_i, bus.lo_i} - r_prod
                                               : {bus.hi_i, bus.lo_i} + r_prod;
`else
          ST_MUL: {r_hi, r_lo} <= w_prod;
`endif
          ST_FIX: {r_hi, r_lo} <= {w_rem, w_quo};
          default: ;
        endcase
      end
    end
  end

  mdu_div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_div_start),
    .i_iter   (w_div_iter),
    .i_fix    (w_div_fix),
    .i_signed (is_signed(bus.op_i)),
    .i_a      (bus.src_a_i),
    .i_b      (bus.src_b_i),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  assign bus.stall_o        = w_stall;
  assign bus.busy_o         = w_busy;
  assign bus.result_valid_o = w_valid;
  assign bus.hi_o           = r_hi;
  assign bus.lo_o           = r_lo;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: vector table, scoreboard of {HI,LO} results, corner sequences.
// Builds with or without MDU_ACC_EN.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
    int          lat;
    logic [63:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  mdu_state_t dbg_state;

  mdu_ctrl_if bus ();

  mdu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int stall_cnt = 0;
  logic [63:0] exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard side: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.stall_o) stall_cnt++;
    if (bus.result_valid_o) begin
      strobe_cnt++;
      strobe_cyc = cyc_n;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got hi=%h lo=%h want none", bus.hi_o, bus.lo_o);
      end else begin
        check("result", {bus.hi_o, bus.lo_o}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] model(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic        sa, sb, sgn;
    sgn = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    if (sgn) p = longint'(int'(a)) * longint'(int'(b));
    else     p = {32'b0, a} * {32'b0, b};
    if (op == OP_DIV || op == OP_DIVU) begin
      sa = sgn && a[31];
      sb = sgn && b[31];
      ma = sa ? 32'(0 - a) : a;
      mb = sb ? 32'(0 - b) : b;
      q  = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
      r  = (mb == 0) ? ma : ma % mb;
      if (sa ^ sb) q = 32'(0 - q);
      if (sa)      r = 32'(0 - r);
      return {r, q};
    end
    if (op == OP_MADD || op == OP_MADDU) return {h, l} + p;
    if (op == OP_MSUB || op == OP_MSUBU) return {h, l} - p;
    return p;
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    int t0, s0, st0, n;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = v.op;
    bus.src_a_i = v.a;
    bus.src_b_i = v.b;
    bus.hi_i    = v.h;
    bus.lo_i    = v.l;
    exp_q.push_back(v.exp);
    t0  = cyc_n;
    s0  = strobe_cnt;
    st0 = stall_cnt;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n = 0;
    while (strobe_cnt == s0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check({name, "_strobes"}, 64'(strobe_cnt - s0), 64'd1);
    if (strobe_cnt == s0) exp_q.delete();
    else begin
      check({name, "_latency"}, 64'(strobe_cyc - t0), 64'(v.lat));
      check({name, "_stall_cycles"}, 64'(stall_cnt - st0), 64'(v.lat));
    end
    @(negedge clk);
    check({name, "_busy_after"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    int s0, n;
    vec_t v;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;
    vec_t v;
    bus.start_i  = 1'b1;
    bus.op_i     = OP_DIVU;
    bus.src_a_i  = 32'd9;
    bus.src_b_i  = 32'd2;
    bus.hi_i     = '0;
    bus.lo_i     = '0;
    bus.cancel_i = 1'b0;
    rst          = 1'b1;

    // Reset holds everything quiet even with start_i asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.result_valid_o), 64'd0);
    check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("rst_state_idle", 64'(dbg_state == ST_IDLE), 64'd1);

    vecs.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'd0, 32'd0, 2,  64'hFFFF_FFFF_FFFF_FFFA});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'd0, 32'd0, 34, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{OP_DIVU,  32'd7,         32'd0,         32'd0, 32'd0, 34, 64'h0000_0007_FFFF_FFFF});
    vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2,  64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{OP_DIVU,  32'd100,       32'd7,         32'd0, 32'd0, 34, 64'h0000_0002_0000_000E});
    vecs.push_back('{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0, 34, 64'h0000_0001_FFFF_FFFD});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'd0, 32'd0, 34, 64'hFFFF_FFF8_0000_0001});
    vecs.push_back('{OP_MULT,  32'h8000_0000, 32'd2,         32'd0, 32'd0, 2,  64'hFFFF_FFFF_0000_0000});
`ifdef MDU_ACC_EN
    vecs.push_back('{OP_MADDU, 32'd1,         32'd1,         32'd0, 32'hFFFF_FFFF, 3, 64'h0000_0001_0000_0000});
    vecs.push_back('{OP_MSUB,  32'd3,         32'd4,         32'd0, 32'd10,        3, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{OP_MADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,         3, 64'h0000_0000_0000_0001});
`endif
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Random operations against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
`ifdef MDU_ACC_EN
      v.op = mdu_op_t'($urandom_range(0, 7));
`else
      v.op = mdu_op_t'($urandom_range(0, 3));
`endif
      v.a   = $urandom;
      v.b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      v.h   = $urandom;
      v.l   = $urandom;
      v.lat = (v.op == OP_DIV || v.op == OP_DIVU) ? 34 : (v.op[2] ? 3 : 2);
      v.exp = model(v.op, v.a, v.b, v.h, v.l);
      run_vec(v, $sformatf("rand%0d", i));
    end

    // Cancel at divide iteration 10, then a fresh multiply.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.src_a_i = 32'd1000; bus.src_b_i = 32'd3;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.cancel_i = 1'b1;
    @(posedge clk); #1;
    bus.cancel_i = 1'b0;
    @(negedge clk);
    check("cancel_idle", 64'(dbg_state == ST_IDLE), 64'd1);
    check("cancel_busy", 64'(bus.busy_o), 64'd0);
    repeat (40) @(posedge clk);
    check("cancel_no_strobe", 64'(strobe_cnt - s0), 64'd0);
    run_vec('{OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd0, 2, 64'd30}, "after_cancel");

    // cancel_i beats start_i in IDLE.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.cancel_i = 1'b1; bus.op_i = OP_DIVU;
    @(negedge clk);
    check("cancel_start_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.cancel_i = 1'b0;
    @(negedge clk);
    check("cancel_start_busy", 64'(bus.busy_o), 64'd0);

    // cancel_i in DONE suppresses the strobe.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = OP_MULT; bus.src_a_i = 32'd3; bus.src_b_i = 32'd4;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.cancel_i = 1'b1;
    @(negedge clk);
    check("done_cancel_state", 64'(dbg_state == ST_DONE), 64'd1);
    check("done_cancel_valid", 64'(bus.result_valid_o), 64'd0);
    @(posedge clk); #1;
    bus.cancel_i = 1'b0;
    @(negedge clk);
    check("done_cancel_idle", 64'(dbg_state == ST_IDLE), 64'd1);

    // start_i held through a divide while op/operands change: one strobe only.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.src_a_i = 32'd100; bus.src_b_i = 32'd7;
    exp_q.push_back(64'h0000_0002_0000_000E);
    s0 = strobe_cnt;
    @(posedge clk); #1;
    bus.op_i = OP_MULTU; bus.src_a_i = 32'd9; bus.src_b_i = 32'd9;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.result_valid_o && n < 60);
    bus.start_i = 1'b0;
    check("held_start_latency", 64'(n), 64'd34);
    repeat (40) @(posedge clk);
    check("held_start_strobes", 64'(strobe_cnt - s0), 64'd1);
    if (strobe_cnt == s0) exp_q.delete();

    // Reset in the middle of a divide overrides cancel/start and clears HI/LO.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = OP_DIV; bus.src_a_i = 32'd50; bus.src_b_i = 32'd5;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; bus.start_i = 1'b1; bus.cancel_i = 1'b1;
    @(negedge clk);
    check("midrst_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.start_i = 1'b0; bus.cancel_i = 1'b0;
    @(negedge clk);
    check("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("midrst_idle", 64'(dbg_state == ST_IDLE), 64'd1);
    repeat (40) @(posedge clk);
    check("midrst_no_strobe", 64'(strobe_cnt - s0), 64'd0);

`ifndef MDU_ACC_EN
    // Accumulate codes are no-ops in this build.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = OP_MADDU; bus.src_a_i = 32'd1; bus.src_b_i = 32'd1;
    bus.hi_i = 32'd0; bus.lo_i = 32'hFFFF_FFFF;
    s0 = strobe_cnt;
    @(negedge clk);
    check("acc_off_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("acc_off_busy", 64'(bus.busy_o), 64'd0);
    repeat (10) @(posedge clk);
    check("acc_off_no_strobe", 64'(strobe_cnt - s0), 64'd0);
`endif

    repeat (2) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
